// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit: one data-memory transaction at a time over req/gnt/rvalid
// Alignment/legality is checked at accept; faulting ops never reach the bus.
module lsu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic        ex_is_load,
    input  logic        ex_is_store,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    input  logic [4:0]  ex_rd,
    input  logic        flush,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        fault,
    output logic [31:0] fault_addr
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t      state, state_nxt;
    logic        kill_q;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;
    logic [4:0]  rd_q;
    logic        accept;
    logic        bad;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;
    logic        store_done;
    logic        load_done;
    logic        killed;

    assign ex_ready   = (state == IDLE);
    assign dmem_req   = (state == REQ);
    assign accept     = ex_valid & ex_ready & ~flush & (ex_is_load | ex_is_store);
    assign store_done = (state == REQ) & dmem_gnt & dmem_we;
    assign load_done  = (state == WAIT) & dmem_rvalid;
    assign killed     = kill_q | flush;

    // funct3[1:0] encodes size (00 byte, 01 half, 10 word) for both loads and stores
    always_comb begin
        bad = 1'b0;
        if (ex_is_load && ex_is_store)
            bad = 1'b1;
        else if (ex_is_load && (ex_funct3 == 3'b011 || ex_funct3[2:1] == 2'b11))
            bad = 1'b1;
        else if (ex_is_store && ex_funct3 >= 3'b011)
            bad = 1'b1;
        else if (ex_funct3[1:0] == 2'b01 && ex_addr[0])
            bad = 1'b1;
        else if (ex_funct3[1:0] == 2'b10 && ex_addr[1:0] != 2'b00)
            bad = 1'b1;
    end

    always_comb begin
        st_be    = 4'b1111;
        st_wdata = ex_wdata;
        if (ex_is_store) begin
            case (ex_funct3[1:0])
                2'b00: begin
                    st_be    = 4'b0001 << ex_addr[1:0];
                    st_wdata = {4{ex_wdata[7:0]}};
                end
                2'b01: begin
                    st_be    = ex_addr[1] ? 4'b1100 : 4'b0011;
                    st_wdata = {2{ex_wdata[15:0]}};
                end
                default: st_be = 4'b1111;
            endcase
        end
    end

    always_comb begin
        ld_byte = dmem_rdata[8*off_q +: 8];
        ld_half = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (funct3_q)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {24'd0, ld_byte};
            3'b101:  ld_ext = {16'd0, ld_half};
            default: ld_ext = dmem_rdata;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept && !bad) state_nxt = REQ;
            REQ:  if (dmem_gnt) state_nxt = dmem_we ? IDLE : WAIT;
            WAIT: if (dmem_rvalid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kill_q     <= 1'b0;
            funct3_q   <= 3'd0;
            off_q      <= 2'd0;
            rd_q       <= 5'd0;
            dmem_we    <= 1'b0;
            dmem_addr  <= 32'd0;
            dmem_be    <= 4'd0;
            dmem_wdata <= 32'd0;
            wb_valid   <= 1'b0;
            wb_we      <= 1'b0;
            wb_rd      <= 5'd0;
            wb_data    <= 32'd0;
            fault      <= 1'b0;
            fault_addr <= 32'd0;
        end else begin
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
            fault    <= 1'b0;
            if (state == IDLE)
                kill_q <= 1'b0;
            else if (flush)
                kill_q <= 1'b1;
            if (accept) begin
                if (bad) begin
                    fault      <= 1'b1;
                    fault_addr <= ex_addr;
                end else begin
                    dmem_we    <= ex_is_store;
                    dmem_addr  <= {ex_addr[31:2], 2'b00};
                    dmem_be    <= st_be;
                    dmem_wdata <= st_wdata;
                    funct3_q   <= ex_funct3;
                    off_q      <= ex_addr[1:0];
                    rd_q       <= ex_rd;
                end
            end
            if (store_done) begin
                wb_valid <= 1'b1;
                wb_rd    <= rd_q;
                wb_data  <= 32'd0;
            end
            // A killed load still drains its rvalid but never writes back
            if (load_done && !killed) begin
                wb_valid <= 1'b1;
                wb_we    <= 1'b1;
                wb_rd    <= rd_q;
                wb_data  <= ld_ext;
            end
        end
    end

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - directed self-checking bench for lsu
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_ready, ex_is_load, ex_is_store;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_addr, ex_wdata;
    logic [4:0]  ex_rd;
    logic        flush;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        wb_valid, wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        fault;
    logic [31:0] fault_addr;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lsu dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
        .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd),
        .flush(flush),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .fault(fault), .fault_addr(fault_addr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one op for exactly one accept edge, then withdraws it
    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd);
        ex_valid    = 1'b1;
        ex_is_load  = ld;
        ex_is_store = st;
        ex_funct3   = f3;
        ex_addr     = addr;
        ex_wdata    = wd;
        ex_rd       = rd;
        tick();
        ex_valid    = 1'b0;
        ex_is_load  = 1'b0;
        ex_is_store = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        ex_valid = 1'b0; ex_is_load = 1'b0; ex_is_store = 1'b0;
        ex_funct3 = 3'd0; ex_addr = 32'd0; ex_wdata = 32'd0; ex_rd = 5'd0;
        flush = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
        #3;
        chk("rst_ex_ready", ex_ready, 1);
        chk("rst_dmem_req", dmem_req, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_fault_addr", fault_addr, 0);
        chk("rst_dmem_addr", dmem_addr, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // SW with immediate grant
        dmem_gnt = 1'b1;
        issue(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 5'd0);
        chk("sw_req", dmem_req, 1);
        chk("sw_we", dmem_we, 1);
        chk("sw_addr", dmem_addr, 32'h100);
        chk("sw_be", dmem_be, 4'b1111);
        chk("sw_wdata", dmem_wdata, 32'hDEADBEEF);
        chk("sw_ready_low", ex_ready, 0);
        tick();
        chk("sw_wb_valid", wb_valid, 1);
        chk("sw_wb_we", wb_we, 0);
        chk("sw_wb_data", wb_data, 0);
        chk("sw_ready", ex_ready, 1);
        tick();
        chk("sw_wb_pulse", wb_valid, 0);

        // SB / SH lane replication
        issue(0, 1, 3'b000, 32'h103, 32'h000000A5, 5'd0);
        chk("sb_addr", dmem_addr, 32'h100);
        chk("sb_be", dmem_be, 4'b1000);
        chk("sb_wdata", dmem_wdata, 32'hA5A5A5A5);
        tick();
        chk("sb_wb_valid", wb_valid, 1);
        issue(0, 1, 3'b001, 32'h102, 32'h00001234, 5'd0);
        chk("sh_be", dmem_be, 4'b1100);
        chk("sh_wdata", dmem_wdata, 32'h12341234);
        tick();
        chk("sh_wb_valid", wb_valid, 1);

        // LB: rvalid held from the REQ cycle must be ignored until WAIT
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h000080FF;
        issue(1, 0, 3'b000, 32'h201, 32'd0, 5'd5);
        chk("lb_req", dmem_req, 1);
        chk("lb_we", dmem_we, 0);
        chk("lb_be", dmem_be, 4'b1111);
        chk("lb_addr", dmem_addr, 32'h200);
        tick();
        chk("lb_wait_no_wb", wb_valid, 0);
        chk("lb_wait_req", dmem_req, 0);
        tick();
        chk("lb_wb_valid", wb_valid, 1);
        chk("lb_wb_we", wb_we, 1);
        chk("lb_wb_rd", wb_rd, 5);
        chk("lb_wb_data", wb_data, 32'hFFFFFF80);
        issue(1, 0, 3'b100, 32'h201, 32'd0, 5'd6);
        tick();
        tick();
        chk("lbu_wb_data", wb_data, 32'h00000080);
        dmem_rdata = 32'h80010000;
        issue(1, 0, 3'b001, 32'h202, 32'd0, 5'd6);
        tick();
        tick();
        chk("lh_wb_valid", wb_valid, 1);
        chk("lh_wb_data", wb_data, 32'hFFFF8001);
        dmem_rvalid = 1'b0;
        dmem_gnt    = 1'b0;
        tick();

        // Faults
        issue(1, 0, 3'b010, 32'h302, 32'd0, 5'd1);
        chk("lw_mis_fault", fault, 1);
        chk("lw_mis_faddr", fault_addr, 32'h302);
        chk("lw_mis_req", dmem_req, 0);
        chk("lw_mis_ready", ex_ready, 1);
        chk("lw_mis_wb", wb_valid, 0);
        tick();
        chk("fault_pulse", fault, 0);
        chk("fault_addr_hold", fault_addr, 32'h302);
        chk("fault_no_req", dmem_req, 0);
        issue(1, 0, 3'b111, 32'h0, 32'd0, 5'd1);
        chk("ld111_fault", fault, 1);
        chk("ld111_faddr", fault_addr, 32'h0);
        tick();

        // LW with delayed grant and rvalid
        issue(1, 0, 3'b010, 32'h400, 32'd0, 5'd7);
        for (int i = 0; i < 3; i++) begin
            chk("dly_req", dmem_req, 1);
            chk("dly_addr", dmem_addr, 32'h400);
            chk("dly_be", dmem_be, 4'b1111);
            chk("dly_we", dmem_we, 0);
            chk("dly_ready", ex_ready, 0);
            if (i < 2) tick();
        end
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        chk("dly_wait_req", dmem_req, 0);
        chk("dly_wait_ready", ex_ready, 0);
        tick();
        chk("dly_wait2_ready", ex_ready, 0);
        chk("dly_wait2_wb", wb_valid, 0);
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hCAFEF00D;
        tick();
        dmem_rvalid = 1'b0;
        chk("dly_wb_valid", wb_valid, 1);
        chk("dly_wb_rd", wb_rd, 7);
        chk("dly_wb_data", wb_data, 32'hCAFEF00D);
        chk("dly_ready_back", ex_ready, 1);
        tick();
        chk("dly_wb_pulse", wb_valid, 0);

        // Flush in WAIT: rvalid consumed, write-back suppressed
        dmem_gnt = 1'b1;
        issue(1, 0, 3'b010, 32'h500, 32'd0, 5'd9);
        tick();
        dmem_gnt = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_still_wait", ex_ready, 0);
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h11112222;
        tick();
        dmem_rvalid = 1'b0;
        chk("fl_no_wb", wb_valid, 0);
        chk("fl_idle", ex_ready, 1);

        // Flush together with ex_valid: no accept
        flush = 1'b1;
        issue(1, 0, 3'b010, 32'h600, 32'd0, 5'd2);
        flush = 1'b0;
        chk("fl_acc_req", dmem_req, 0);
        chk("fl_acc_ready", ex_ready, 1);
        chk("fl_acc_fault", fault, 0);
        // Neither load nor store: ignored
        issue(0, 0, 3'b010, 32'h600, 32'd0, 5'd2);
        chk("nop_req", dmem_req, 0);
        chk("nop_fault", fault, 0);

        // Reset while in WAIT
        dmem_gnt = 1'b1;
        issue(1, 0, 3'b010, 32'h700, 32'd0, 5'd3);
        tick();
        dmem_gnt = 1'b0;
        chk("rw_in_wait", ex_ready, 0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rw_ready", ex_ready, 1);
        chk("rw_req", dmem_req, 0);
        chk("rw_addr", dmem_addr, 0);
        chk("rw_be", dmem_be, 0);
        chk("rw_wdata", dmem_wdata, 0);
        chk("rw_we", dmem_we, 0);
        chk("rw_wb_data", wb_data, 0);
        chk("rw_wb_rd", wb_rd, 0);
        chk("rw_faddr", fault_addr, 0);
        tick();
        rst_n = 1'b1;
        dmem_rvalid = 1'b1;
        tick();
        dmem_rvalid = 1'b0;
        chk("rw_lost_op", wb_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit sitting directly downstream of the execute-stage ALU. It takes the ALU result as the effective address, plus rs2 store data and the decoded funct3. It runs one data-memory transaction at a time over a req/gnt/rvalid bus and returns aligned, sign- or zero-extended load data to write-back. Misaligned or illegal accesses raise a fault and never reach the bus.

## Interface
- No parameters. Address and data are fixed at 32 bits.
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ex_valid  in  1  EX stage presents a memory op
- ex_ready  out  1  LSU can accept; combinational, equals (state==IDLE)
- ex_is_load  in  1  op is a load
- ex_is_store  in  1  op is a store
- ex_funct3  in  3  width/sign code, RV32I encoding
- ex_addr  in  32  effective address (ALU output)
- ex_wdata  in  32  store data (rs2)
- ex_rd  in  5  load destination register
- flush  in  1  pipeline kill
- dmem_req  out  1  bus request
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word address, {ex_addr[31:2],2'b00}
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-replicated store data
- dmem_gnt  in  1  request accepted this cycle
- dmem_rvalid  in  1  read data valid
- dmem_rdata  in  32  read data
- wb_valid  out  1  one-cycle completion pulse
- wb_we  out  1  1 = write wb_data to wb_rd (loads only)
- wb_rd  out  5  destination register
- wb_data  out  32  extended load data, 0 for stores
- fault  out  1  one-cycle misalign/illegal pulse
- fault_addr  out  32  offending address, held until the next fault

## Operation
- FSM states: IDLE, REQ, WAIT.
- Accept condition: ex_valid & ex_ready & ~flush & (ex_is_load | ex_is_store).
  - If flush is high in the same cycle, nothing is accepted.
  - If both is_load and is_store are 0, the op is ignored.
- Fault check at accept. A fault is raised on any of:
  - both is_load and is_store set;
  - load funct3 in {011,110,111};
  - store funct3 ≥ 011;
  - halfword with addr[0]=1;
  - word with addr[1:0]≠0.
- On fault: fault pulses next cycle, fault_addr=ex_addr, state stays IDLE, no bus activity.
- Good accept: latch we, addr, be, wdata, funct3, rd; go to REQ.
- Store lanes:
  - SB: wdata={4{b}}, be=4'b0001<<addr[1:0].
  - SH: wdata={2{h}}, be=addr[1]?1100:0011.
  - SW: be=1111.
- Loads: be=1111. Extraction selects the byte at addr[1:0] or the halfword at addr[1]:
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Transitions:
  - REQ: dmem_req=1 with all dmem_* held stable until gnt.
  - REQ + gnt, store: go to IDLE; wb_valid=1, wb_we=0 next cycle.
  - REQ + gnt, load: go to WAIT.
  - WAIT + rvalid: go to IDLE; wb_valid=1, wb_we=1, wb_data=extracted next cycle.
- Flush during REQ/WAIT does not abort the bus transaction; stores always complete.
  - A flushed load still waits for rvalid, but its wb_valid is suppressed.
  - The flush is recorded in a sticky kill bit, cleared on return to IDLE.
- dmem_gnt outside REQ and dmem_rvalid outside WAIT are ignored. rvalid in the same cycle as gnt is ignored.

## Timing
- Reset (async, immediate) sets state=IDLE, so ex_ready=1.
  - All other outputs are 0: dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, wb_valid, wb_we, wb_rd, wb_data, fault, fault_addr.
- Reset mid-transaction drops dmem_req asynchronously; the in-flight op is lost.
- Accept at edge N gives dmem_req high in cycle N+1.
- Store, gnt in N+1: wb_valid in N+2. A new accept is possible at the N+2 edge.
- Load, gnt N+1, rvalid N+2: wb_valid and wb_data in N+3. Minimum load latency is 3 cycles; each extra gnt or rvalid wait cycle adds one.
- wb_valid and fault are single-cycle pulses and are mutually exclusive.
- ex_ready is low in REQ and WAIT.

## Test plan
- SW addr=0x100 wdata=0xDEADBEEF, gnt immediate -> dmem_addr=0x100, be=1111, wdata=0xDEADBEEF in N+1; wb_valid=1, wb_we=0 in N+2.
- SB addr=0x103 wdata=0x000000A5 -> be=1000, wdata=0xA5A5A5A5; SH addr=0x102 wdata=0x1234 -> be=1100, wdata=0x12341234.
- LB addr=0x201, rdata=0x0000_80FF -> wb_data=0xFFFFFF80; LBU same -> 0x00000080; LH addr=0x202, rdata=0x8001_0000 -> 0xFFFF8001.
- LW addr=0x302 -> fault=1 at N+1, fault_addr=0x302, dmem_req never asserts, ex_ready stays 1; load funct3=111 addr=0 -> fault.
- LW with gnt delayed 3 cycles and rvalid 2 cycles later -> dmem_* stable throughout REQ; wb_valid exactly 1 cycle, rd correct, ex_ready low until return to IDLE.
- Flush asserted in WAIT -> rvalid consumed, no wb_valid; flush in the same cycle as ex_valid -> no accept. Reset asserted in WAIT -> dmem_req=0 and all outputs 0 immediately.
